// File: rtl/memory_pkg.sv
// Shared types and constants for the core-memory access sequencer.
package memory_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_STORE,
        S_DONE
    } state_e;

    localparam int T_RD_DEF = 4;
    localparam int T_WR_DEF = 4;

    localparam int FIELD_W = 3;
    localparam int X_LSB   = 0;
    localparam int Y_LSB   = 3;
    localparam int X0_LSB  = 6;
    localparam int Y0_LSB  = 9;

endpackage

// File: rtl/memory_sequencer_onehot_n_dec.sv
// 3-to-8 active-low one-hot decoder with enable; all outputs high when disabled.
module onehot_n_dec (
    input  logic [2:0] in_i,
    input  logic       en_i,
    output logic [7:0] sel_vn_o
);

    always_comb begin
        sel_vn_o = 8'hFF;
        if (en_i) begin
            sel_vn_o[in_i] = 1'b0;
        end
    end

endmodule

// File: rtl/memory_sequencer.sv
// Core-memory access sequencer: address, read, store/restore, done phases.
// MEMORY_SEQUENCER_PARITY_EN enables odd-parity checking of the read syllable.
module memory_sequencer
    import memory_pkg::*;
#(
    parameter int T_RD = T_RD_DEF,
    parameter int T_WR = T_WR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wr,
    input  logic [11:0] addr,
    input  logic        syl,
    input  logic [13:0] sa,
    output logic [7:0]  ax_vn,
    output logic [7:0]  ay_vn,
    output logic [7:0]  ax0_vn,
    output logic [7:0]  ay0_vn,
    output logic        rdmv,
    output logic        rdmvn,
    output logic        syncv,
    output logic        syl0vn,
    output logic        syl1vn,
    output logic        inhbsv,
    output logic        busy,
    output logic [13:0] rd_data,
    output logic        par_err,
    output logic        done
);

    localparam logic [3:0] RD_INIT = 4'(T_RD - 1);
    localparam logic [3:0] WR_INIT = 4'(T_WR - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] addr_q, addr_d;
    logic        syl_q, syl_d;
    logic        wr_q, wr_d;
    logic [13:0] rd_data_q, rd_data_d;
    logic        rd_load;
    logic        sel_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 12'd0;
            syl_q     <= 1'b0;
            wr_q      <= 1'b0;
            rd_data_q <= 14'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            syl_q     <= syl_d;
            wr_q      <= wr_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        syl_d     = syl_q;
        wr_d      = wr_q;
        rd_load   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_ADDR;
                    addr_d  = addr;
                    syl_d   = syl;
                    wr_d    = wr;
                end
            end
            S_ADDR: begin
                state_d = S_READ;
                cnt_d   = RD_INIT;
            end
            S_READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_STORE;
                    cnt_d   = WR_INIT;
                    rd_load = !wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STORE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        rd_data_d = rd_load ? sa : rd_data_q;
    end

`ifdef MEMORY_SEQUENCER_PARITY_EN
    logic par_q;

    // Odd parity is good; an even count of ones flags an error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (rd_load) begin
            par_q <= ~(^sa);
        end
    end

    assign par_err = par_q;
`else
    assign par_err = 1'b0;
`endif

    assign sel_en  = (state_q == S_ADDR) || (state_q == S_READ)
                  || (state_q == S_STORE);
    assign busy    = (state_q != S_IDLE);
    assign rdmv    = (state_q == S_READ);
    assign rdmvn   = ~rdmv;
    assign syncv   = ((state_q == S_READ) && (cnt_q == RD_INIT))
                  || ((state_q == S_STORE) && (cnt_q == WR_INIT));
    assign inhbsv  = (state_q == S_STORE) && wr_q;
    assign done    = (state_q == S_DONE);
    assign syl0vn  = busy ? syl_q : 1'b1;
    assign syl1vn  = busy ? ~syl_q : 1'b1;
    assign rd_data = rd_data_q;

    onehot_n_dec u_dec_x (
        .in_i     (addr_q[X_LSB +: FIELD_W]),
        .en_i     (sel_en),
        .sel_vn_o (ax_vn)
    );

    onehot_n_dec u_dec_y (
        .in_i     (addr_q[Y_LSB +: FIELD_W]),
        .en_i     (sel_en),
        .sel_vn_o (ay_vn)
    );

    onehot_n_dec u_dec_x0 (
        .in_i     (addr_q[X0_LSB +: FIELD_W]),
        .en_i     (sel_en),
        .sel_vn_o (ax0_vn)
    );

    onehot_n_dec u_dec_y0 (
        .in_i     (addr_q[Y0_LSB +: FIELD_W]),
        .en_i     (sel_en),
        .sel_vn_o (ay0_vn)
    );

endmodule

// File: tb/tb_memory_sequencer.sv
// Self-checking bench for memory_sequencer: vector table, corner sequences,
// and randomized traffic against a cycle-position reference model.
module tb_memory_sequencer;

    localparam int TRD = 4;
    localparam int TWR = 4;
`ifdef MEMORY_SEQUENCER_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, req, wr, syl;
    logic [11:0] addr;
    logic [13:0] sa;
    logic [7:0]  ax_vn, ay_vn, ax0_vn, ay0_vn;
    logic        rdmv, rdmvn, syncv, syl0vn, syl1vn, inhbsv, busy;
    logic [13:0] rd_data;
    logic        par_err, done;

    int n_cmp = 0;
    int n_bad = 0;

    memory_sequencer #(.T_RD(TRD), .T_WR(TWR)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr),
        .syl(syl), .sa(sa), .ax_vn(ax_vn), .ay_vn(ay_vn),
        .ax0_vn(ax0_vn), .ay0_vn(ay0_vn), .rdmv(rdmv), .rdmvn(rdmvn),
        .syncv(syncv), .syl0vn(syl0vn), .syl1vn(syl1vn),
        .inhbsv(inhbsv), .busy(busy), .rd_data(rd_data),
        .par_err(par_err), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: position of the access in cycles since acceptance.
    bit          m_act = 1'b0;
    int          m_t = 0;
    logic [11:0] m_addr = '0;
    logic        m_syl = 1'b0;
    logic        m_wr = 1'b0;
    logic [13:0] m_rd = '0;
    logic        m_par = 1'b0;
    int          m_dones = 0;
    int          d_dones = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_sel(input bit on,
                                           input logic [2:0] f);
        logic [7:0] v;
        v = 8'hFF;
        if (on) v[f] = 1'b0;
        return v;
    endfunction

    task automatic check_all();
        bit on, rdp, stp, dn;
        on  = m_act && (m_t <= TRD + TWR);
        rdp = m_act && (m_t >= 1) && (m_t <= TRD);
        stp = m_act && (m_t > TRD) && (m_t <= TRD + TWR);
        dn  = m_act && (m_t == TRD + TWR + 1);
        chk("ax_vn", ax_vn, exp_sel(on, m_addr[2:0]));
        chk("ay_vn", ay_vn, exp_sel(on, m_addr[5:3]));
        chk("ax0_vn", ax0_vn, exp_sel(on, m_addr[8:6]));
        chk("ay0_vn", ay0_vn, exp_sel(on, m_addr[11:9]));
        chk("rdmv", rdmv, rdp);
        chk("rdmvn", rdmvn, !rdp);
        chk("syncv", syncv, m_act && (m_t == 1 || m_t == TRD + 1));
        chk("syl0vn", syl0vn, m_act ? m_syl : 1'b1);
        chk("syl1vn", syl1vn, m_act ? !m_syl : 1'b1);
        chk("inhbsv", inhbsv, stp && m_wr);
        chk("busy", busy, m_act);
        chk("done", done, dn);
        chk("rd_data", rd_data, m_rd);
        chk("par_err", par_err, m_par);
    endtask

    task automatic tick();
        logic r, q, w, y;
        logic [11:0] a;
        logic [13:0] s;
        r = rst_n; q = req; w = wr; y = syl; a = addr; s = sa;
        @(posedge clk);
        if (!r) begin
            m_act = 1'b0;
            m_rd  = '0;
            m_par = 1'b0;
        end else if (m_act) begin
            if (m_t == TRD && !m_wr) begin
                m_rd = s;
                if (PAR_ON) m_par = ~(^s);
            end
            m_t++;
            if (m_t > TRD + TWR + 1) m_act = 1'b0;
        end else if (q) begin
            m_act = 1'b1; m_t = 0;
            m_addr = a; m_syl = y; m_wr = w;
        end
        if (m_act && m_t == TRD + TWR + 1) m_dones++;
        #1;
        if (done) d_dones++;
        check_all();
    endtask

    typedef struct {
        logic [11:0] addr;
        logic        syl;
        logic        wr;
        logic [13:0] sa;
        logic [7:0]  eax, eay, eax0, eay0;
        logic [13:0] erd;
        logic        epar;
    } vec_t;

    vec_t vecs[4];

    // Cycle numbering: the accepting IDLE cycle is 0, ADDR is cycle 1.
    task automatic apply(input vec_t v, output int cyc, output int n_inh,
                         output int s1, output int s2);
        addr = v.addr; syl = v.syl; wr = v.wr; sa = v.sa; req = 1'b1;
        tick();
        req = 1'b0; addr = ~v.addr; syl = ~v.syl; wr = ~v.wr;
        chk("vec_ax", ax_vn, v.eax);
        chk("vec_ay", ay_vn, v.eay);
        chk("vec_ax0", ax0_vn, v.eax0);
        chk("vec_ay0", ay0_vn, v.eay0);
        chk("vec_syl0vn", syl0vn, v.syl);
        cyc = 1; n_inh = 0; s1 = -1; s2 = -1;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
            if (inhbsv) n_inh++;
            if (syncv) begin
                if (s1 < 0) s1 = cyc;
                else s2 = cyc;
            end
        end
        chk("done_cycle", cyc, 2 + TRD + TWR);
        chk("vec_rd_data", rd_data, v.erd);
        chk("vec_par_err", par_err, v.epar);
        tick();
    endtask

    initial begin
        int cyc, n_inh, s1, s2;
        vecs[0] = '{12'o7053, 1'b0, 1'b0, 14'h1FFF,
                    8'hF7, 8'hDF, 8'hFE, 8'h7F, 14'h1FFF, 1'b0};
        vecs[1] = '{12'o0000, 1'b1, 1'b0, 14'h0003,
                    8'hFE, 8'hFE, 8'hFE, 8'hFE, 14'h0003, PAR_ON};
        vecs[2] = '{12'o1234, 1'b0, 1'b0, 14'h0001,
                    8'hEF, 8'hF7, 8'hFB, 8'hFD, 14'h0001, 1'b0};
        vecs[3] = '{12'o7777, 1'b1, 1'b1, 14'h2AAA,
                    8'h7F, 8'h7F, 8'h7F, 8'h7F, 14'h0001, 1'b0};

        rst_n = 1'b0; req = 1'b1; wr = 1'b0; syl = 1'b0;
        addr = 12'o7053; sa = 14'h3FFF;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_ax_vn", ax_vn, 8'hFF);
        chk("rst_rdmvn", rdmvn, 1'b1);
        chk("rst_syl1vn", syl1vn, 1'b1);
        chk("rst_rd_data", rd_data, 14'h0000);
        rst_n = 1'b1; req = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            apply(vecs[i], cyc, n_inh, s1, s2);
            if (vecs[i].wr) begin
                chk("wr_inhbsv_cycles", n_inh, TWR);
                chk("wr_sync_gap", s2 - s1, TRD);
            end else begin
                chk("rd_inhbsv_cycles", n_inh, 0);
            end
        end

        m_dones = 0; d_dones = 0;
        req = 1'b1; wr = 1'b0; addr = 12'o4321; sa = 14'h0155;
        for (int i = 0; i < 33; i++) tick();
        req = 1'b0;
        chk("held_req_dones", d_dones, 3);
        chk("held_req_model", d_dones, m_dones);
        while (busy && cyc < 80) begin tick(); cyc++; end

        d_dones = 0;
        req = 1'b1; wr = 1'b0; addr = 12'o0707; sa = 14'h0007;
        tick();
        req = 1'b0;
        tick();
        tick();
        chk("mid_in_read", rdmv, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_ay0", ay0_vn, 8'hFF);
        chk("abort_syl0vn", syl0vn, 1'b1);
        chk("abort_rd_data", rd_data, 14'h0000);
        for (int i = 0; i < 12; i++) tick();
        chk("abort_no_done", d_dones, 0);
        apply(vecs[0], cyc, n_inh, s1, s2);

        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            req   = ($urandom_range(0, 3) != 0);
            wr    = 1'($urandom);
            syl   = 1'($urandom);
            addr  = 12'($urandom);
            sa    = 14'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
